// File: rtl/tdm_mux_sequencer_if.sv
// Channel-word handshake between a word producer and the TDM mux sequencer.
// The producer drives data/valid; the sequencer answers with ready.
interface tdm_mux_sequencer_if;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/tdm_mux_sequencer.sv
// Control stage for a 4:1 enable-gated mux: frames one buffered 4-bit word
// per frame, stepping select through slots 0..3, SLOT_CYCLES clocks each.
module tdm_mux_sequencer #(
    parameter  int SLOT_CYCLES = 4,
    localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    tdm_mux_sequencer_if.slave    bus,
    output logic [3:0]            d,
    output logic                  e,
    output logic [1:0]            s,
    output logic                  frame_start,
    output logic                  busy,
    output logic                  underrun
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [CNT_W-1:0] TERM = CNT_W'(SLOT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       buf_q, buf_d;
    logic             full_q, full_d;
    logic [3:0]       act_q, act_d;
    logic [1:0]       slot_q, slot_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fs_q, fs_d;
    logic             ur_q, ur_d;

    logic hs;
    logic term;
    logic fend;
    logic load;

    assign bus.in_ready = !rst && !full_q;

    assign hs   = bus.in_valid && bus.in_ready;
    assign term = (cnt_q == TERM);
    assign fend = (state_q == RUN) && (slot_q == 2'd3) && term;
    assign load = full_q && run && ((state_q == IDLE) || fend);

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        full_d  = full_q;
        act_d   = act_q;
        slot_d  = slot_q;
        cnt_d   = cnt_q;
        fs_d    = 1'b0;
        ur_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                slot_d = 2'd0;
                cnt_d  = '0;
            end
            RUN: begin
                if (term) begin
                    cnt_d  = '0;
                    slot_d = slot_q + 2'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // No word to chain: drop back to idle after slot 3.
                if (fend && !load) begin
                    state_d = IDLE;
                    ur_d    = run;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            state_d = RUN;
            act_d   = buf_q;
            full_d  = 1'b0;
            slot_d  = 2'd0;
            cnt_d   = '0;
            fs_d    = 1'b1;
        end

        if (hs) begin
            buf_d  = bus.in_data;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            buf_q   <= 4'd0;
            full_q  <= 1'b0;
            act_q   <= 4'd0;
            slot_q  <= 2'd0;
            cnt_q   <= '0;
            fs_q    <= 1'b0;
            ur_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            full_q  <= full_d;
            act_q   <= act_d;
            slot_q  <= slot_d;
            cnt_q   <= cnt_d;
            fs_q    <= fs_d;
            ur_q    <= ur_d;
        end
    end

    assign d           = act_q;
    assign e           = (state_q == RUN);
    assign s           = slot_q;
    assign frame_start = fs_q;
    assign busy        = (state_q == RUN);
    assign underrun    = ur_q;

endmodule

// File: tb/tb_tdm_mux_sequencer.sv
// Scoreboard bench: two sequencers (SLOT_CYCLES 4 and 1) against a
// frame-position reference model and a queue of accepted words.
module tb_tdm_mux_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_r [2];
    logic       run_r [2];
    logic       vld_r [2];
    logic [3:0] dat_r [2];

    logic       rdy_w [2];
    logic [3:0] d_w   [2];
    logic       e_w   [2];
    logic [1:0] s_w   [2];
    logic       fs_w  [2];
    logic       bsy_w [2];
    logic       ur_w  [2];

    int errors = 0;
    int checks = 0;

    tdm_mux_sequencer_if ifa ();
    tdm_mux_sequencer_if ifb ();

    assign ifa.in_valid = vld_r[0];
    assign ifa.in_data  = dat_r[0];
    assign ifb.in_valid = vld_r[1];
    assign ifb.in_data  = dat_r[1];
    assign rdy_w[0]     = ifa.in_ready;
    assign rdy_w[1]     = ifb.in_ready;

    tdm_mux_sequencer #(.SLOT_CYCLES(4)) dut4 (
        .clk         (clk),
        .rst         (rst_r[0]),
        .run         (run_r[0]),
        .bus         (ifa.slave),
        .d           (d_w[0]),
        .e           (e_w[0]),
        .s           (s_w[0]),
        .frame_start (fs_w[0]),
        .busy        (bsy_w[0]),
        .underrun    (ur_w[0])
    );

    tdm_mux_sequencer #(.SLOT_CYCLES(1)) dut1 (
        .clk         (clk),
        .rst         (rst_r[1]),
        .run         (run_r[1]),
        .bus         (ifb.slave),
        .d           (d_w[1]),
        .e           (e_w[1]),
        .s           (s_w[1]),
        .frame_start (fs_w[1]),
        .busy        (bsy_w[1]),
        .underrun    (ur_w[1])
    );

    // Reference model: position inside the frame, -1 when idle.
    int         m_pos [2] = '{-1, -1};
    logic [3:0] m_cur [2] = '{4'd0, 4'd0};
    logic       m_pv  [2] = '{1'b0, 1'b0};
    logic [3:0] m_pw  [2] = '{4'd0, 4'd0};
    logic       m_ur  [2] = '{1'b0, 1'b0};

    logic [3:0] sb0 [$];
    logic [3:0] sb1 [$];

    function automatic int sc(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    task automatic model_step(input int k);
        logic hs;
        logic fend;
        logic idle;
        hs = vld_r[k] && !m_pv[k] && !rst_r[k];
        if (rst_r[k]) begin
            m_pos[k] = -1;
            m_cur[k] = 4'd0;
            m_pv[k]  = 1'b0;
            m_ur[k]  = 1'b0;
            if (k == 0) sb0.delete();
            else        sb1.delete();
        end else begin
            fend    = (m_pos[k] == 4 * sc(k) - 1);
            idle    = (m_pos[k] < 0);
            m_ur[k] = 1'b0;
            if ((idle || fend) && run_r[k] && m_pv[k]) begin
                m_cur[k] = m_pw[k];
                m_pv[k]  = 1'b0;
                m_pos[k] = 0;
            end else if (fend) begin
                m_pos[k] = -1;
                m_ur[k]  = run_r[k];
            end else if (!idle) begin
                m_pos[k] = m_pos[k] + 1;
            end
            if (hs) begin
                m_pv[k] = 1'b1;
                m_pw[k] = dat_r[k];
                if (k == 0) sb0.push_back(dat_r[k]);
                else        sb1.push_back(dat_r[k]);
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    task automatic monitor(input int k);
        logic [10:0] act;
        logic [10:0] exp_v;
        logic        ee;
        logic [1:0]  es;
        logic [3:0]  w;
        logic        empty;
        ee    = (m_pos[k] >= 0);
        es    = ee ? 2'(m_pos[k] / sc(k)) : 2'd0;
        exp_v = {m_cur[k], ee, es, (m_pos[k] == 0), ee, m_ur[k],
                 (!rst_r[k] && !m_pv[k])};
        act   = {d_w[k], e_w[k], s_w[k], fs_w[k], bsy_w[k], ur_w[k],
                 rdy_w[k]};
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL outs[%0d] t=%0t got d,e,s,fs,busy,ur,rdy=%b want %b",
                     k, $time, act, exp_v);
        end
        if (fs_w[k] === 1'b1) begin
            empty = (k == 0) ? (sb0.size() == 0) : (sb1.size() == 0);
            checks++;
            if (empty) begin
                errors++;
                $display("FAIL word[%0d] t=%0t got d=%h want none pending",
                         k, $time, d_w[k]);
            end else begin
                w = (k == 0) ? sb0.pop_front() : sb1.pop_front();
                if (d_w[k] !== w) begin
                    errors++;
                    $display("FAIL word[%0d] t=%0t got d=%h want %h",
                             k, $time, d_w[k], w);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        monitor(0);
        monitor(1);
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(input int k, input logic [3:0] w, input bit keep);
        logic r;
        bit   ok;
        ok       = 1'b0;
        vld_r[k] = 1'b1;
        dat_r[k] = w;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            r = rdy_w[k];
            @(posedge clk);
            #2;
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept[%0d] got no in_ready want word %h taken", k, w);
        end
        if (!keep) vld_r[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (m_pos[k] < 0 && !m_pv[k]) begin
                ok = 1'b1;
                break;
            end
            cyc(1);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL idle[%0d] got busy want idle within 300 cycles", k);
        end
    endtask

    task automatic rand_run(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            vld_r[k] = ($urandom_range(0, 1) == 1);
            dat_r[k] = 4'($urandom);
            run_r[k] = ($urandom_range(0, 3) != 0);
            rst_r[k] = ($urandom_range(0, 99) == 0);
            cyc(1);
        end
        vld_r[k] = 1'b0;
        rst_r[k] = 1'b0;
        run_r[k] = 1'b1;
    endtask

    task automatic seq0();
        cyc(2);
        rst_r[0] = 1'b0;
        run_r[0] = 1'b1;
        send(0, 4'b1010, 1'b0);
        wait_idle(0);
        cyc(3);
        send(0, 4'hC, 1'b0);
        send(0, 4'h3, 1'b0);
        wait_idle(0);
        cyc(3);
        send(0, 4'h1, 1'b1);
        send(0, 4'h2, 1'b1);
        send(0, 4'h4, 1'b0);
        wait_idle(0);
        cyc(2);
        run_r[0] = 1'b0;
        send(0, 4'h9, 1'b0);
        cyc(20);
        run_r[0] = 1'b1;
        cyc(5);
        run_r[0] = 1'b0;
        cyc(25);
        run_r[0] = 1'b1;
        send(0, 4'h6, 1'b0);
        send(0, 4'hE, 1'b0);
        cyc(8);
        rst_r[0] = 1'b1;
        cyc(1);
        rst_r[0] = 1'b0;
        cyc(20);
        rand_run(0, 600);
        wait_idle(0);
    endtask

    task automatic seq1();
        cyc(2);
        rst_r[1] = 1'b0;
        run_r[1] = 1'b1;
        send(1, 4'b0110, 1'b0);
        wait_idle(1);
        cyc(3);
        send(1, 4'h5, 1'b0);
        send(1, 4'hA, 1'b0);
        wait_idle(1);
        rand_run(1, 400);
        wait_idle(1);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_r[k] = 1'b1;
            run_r[k] = 1'b0;
            vld_r[k] = 1'b0;
            dat_r[k] = 4'd0;
        end
        fork
            seq0();
            seq1();
        join
        cyc(4);
        checks++;
        if (sb0.size() != 0 || sb1.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d/%0d words unframed want 0/0",
                     sb0.size(), sb1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
